// File: rtl/sbn_ctrl_pkg.sv
// Shared encodings for the SBN run controller: host opcodes, response status
// codes and the controller FSM states.
package sbn_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_WR_IMEM = 3'd0,
    OP_WR_REG  = 3'd1,
    OP_RD_REG  = 3'd2,
    OP_CLEAR   = 3'd3,
    OP_RUN     = 3'd4,
    OP_STATUS  = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1,
    RSP_ERR     = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CLEAR,
    S_RUN,
    S_RESP
  } state_e;

  localparam int unsigned CMD_ADDR_W = 5;
  localparam int unsigned CMD_DATA_W = 32;

endpackage

// File: rtl/sbn_imem_buffer.sv
// Instruction word store: single write port, all words presented on a
// flattened bus (word i at bits [i*WIDTH +: WIDTH]).
module sbn_imem_buffer
  import sbn_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [CMD_ADDR_W-1:0]  wr_addr_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic [DEPTH*WIDTH-1:0] words_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else if (wr_en_i && (32'(wr_addr_i) == i)) begin
        mem_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    words_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      words_o[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/sbn_run_controller.sv
// Host command front-end for the SBN datapath: loads the program, pokes/peeks
// registers, clears and runs the datapath under a cycle budget.
module sbn_run_controller
  import sbn_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned REG_WIDTH   = 16,
  parameter int unsigned REG_DEPTH   = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_op,
  input  logic [CMD_ADDR_W-1:0]             cmd_addr,
  input  logic [CMD_DATA_W-1:0]             cmd_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [31:0]                       rsp_data,
  output logic [1:0]                        rsp_status,
  output logic                              dp_reset,
  output logic                              dp_enable,
  output logic [CMD_ADDR_W-1:0]             dp_reg_addr,
  output logic [REG_WIDTH-1:0]              dp_reg_wdata,
  output logic                              dp_reg_we,
  input  logic [REG_WIDTH-1:0]              dp_reg_rdata,
  input  logic                              dp_done,
  input  logic [15:0]                       dp_executed,
  output logic [IMEM_DEPTH*INSTR_WIDTH-1:0] dp_instructions
);

  state_e                state_q, state_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  rsp_status_e           rsp_status_q, rsp_status_d;
  logic                  imem_we;

  sbn_imem_buffer #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_WIDTH)
  ) u_imem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (imem_we),
    .wr_addr_i (cmd_addr),
    .wr_data_i (INSTR_WIDTH'(cmd_data)),
    .words_o   (dp_instructions)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= RSP_OK;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    imem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d       = cmd_addr;
          wdata_d      = REG_WIDTH'(cmd_data);
          rsp_data_d   = '0;
          rsp_status_d = RSP_OK;
          state_d      = S_RESP;
          case (cmd_op_e'(cmd_op))
            OP_WR_IMEM: imem_we = 1'b1;
            OP_WR_REG: begin
              if ((cmd_addr == '0) || (32'(cmd_addr) >= REG_DEPTH)) rsp_status_d = RSP_ERR;
              else                                                  state_d      = S_WRITE;
            end
            OP_RD_REG: state_d = S_READ;
            OP_CLEAR:  state_d = S_CLEAR;
            OP_RUN: begin
              if (dp_done || (cmd_data == '0)) begin
                rsp_status_d = RSP_ERR;
              end else begin
                cnt_d   = cmd_data;
                state_d = S_RUN;
              end
            end
            OP_STATUS: begin
              rsp_data_d   = 32'(dp_executed);
              rsp_status_d = dp_done ? RSP_OK : RSP_TIMEOUT;
            end
            default: rsp_status_d = RSP_ERR;
          endcase
        end
      end
      S_WRITE: state_d = S_RESP;
      S_READ: begin
        rsp_data_d = 32'(dp_reg_rdata);
        state_d    = S_RESP;
      end
      S_CLEAR: state_d = S_RESP;
      S_RUN: begin
        // Budget cycle count equals enabled cycles; a same-cycle done takes precedence.
        cnt_d = (cnt_q != '0) ? cnt_q - 32'd1 : '0;
        if (dp_done) begin
          rsp_data_d   = 32'(dp_executed);
          rsp_status_d = RSP_OK;
          state_d      = S_RESP;
        end else if (cnt_q <= 32'd1) begin
          rsp_data_d   = 32'(dp_executed);
          rsp_status_d = RSP_TIMEOUT;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid    = (state_q == S_RESP);
    cmd_ready    = (state_q == S_IDLE) && !rsp_valid;
    rsp_data     = rsp_data_q;
    rsp_status   = rsp_status_q;
    dp_reset     = reset || (state_q == S_CLEAR);
    dp_enable    = (state_q == S_RUN);
    dp_reg_we    = (state_q == S_WRITE);
    dp_reg_addr  = ((state_q == S_WRITE) || (state_q == S_READ)) ? addr_q : '0;
    dp_reg_wdata = (state_q == S_WRITE) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_sbn_run_controller.sv
// Bench for sbn_run_controller: a behavioural datapath stub drives dp_* and a
// command-level reference model predicts every response.
module tb_sbn_run_controller;
  import sbn_ctrl_pkg::*;

  localparam int unsigned IMEM_DEPTH  = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned REG_WIDTH   = 16;
  localparam int unsigned REG_DEPTH   = 32;
  localparam logic [31:0] HALT        = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [4:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0] rsp_status;
  logic dp_reset, dp_enable, dp_reg_we;
  logic [4:0] dp_reg_addr;
  logic [REG_WIDTH-1:0] dp_reg_wdata, dp_reg_rdata;
  logic dp_done = 1'b0;
  logic [15:0] dp_executed = '0;
  logic [IMEM_DEPTH*INSTR_WIDTH-1:0] dp_instructions;

  always #5 clk = ~clk;

  sbn_run_controller #(
    .IMEM_DEPTH(IMEM_DEPTH), .INSTR_WIDTH(INSTR_WIDTH),
    .REG_WIDTH(REG_WIDTH), .REG_DEPTH(REG_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .dp_reset(dp_reset), .dp_enable(dp_enable),
    .dp_reg_addr(dp_reg_addr), .dp_reg_wdata(dp_reg_wdata), .dp_reg_we(dp_reg_we),
    .dp_reg_rdata(dp_reg_rdata), .dp_done(dp_done), .dp_executed(dp_executed),
    .dp_instructions(dp_instructions)
  );

  int checks = 0, failures = 0;
  int en_cnt = 0, clr_cnt = 0;

  // Datapath stub: executes one word per enabled cycle, HALT word sets done.
  logic [REG_WIDTH-1:0] dp_regs [REG_DEPTH];
  logic [4:0] dp_pc = '0;
  initial for (int i = 0; i < int'(REG_DEPTH); i++) dp_regs[i] = '0;
  assign dp_reg_rdata = dp_regs[dp_reg_addr];

  always @(posedge clk) begin
    if (dp_reg_we) dp_regs[dp_reg_addr] <= dp_reg_wdata;
    if (dp_reset) begin
      dp_pc <= '0; dp_executed <= '0; dp_done <= 1'b0;
    end else if (dp_enable && !dp_done) begin
      if (dp_instructions[dp_pc*INSTR_WIDTH +: INSTR_WIDTH] == HALT) dp_done <= 1'b1;
      else begin dp_executed <= dp_executed + 16'd1; dp_pc <= dp_pc + 5'd1; end
    end
    if (dp_enable) en_cnt <= en_cnt + 1;
    if (dp_reset && !reset) clr_cnt <= clr_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (dp_reg_we && dp_enable) begin
        failures++; $display("FAIL we_enable_excl: we=%b enable=%b, required not both 1", dp_reg_we, dp_enable);
      end
    end
  end

  // Reference model state at command granularity.
  logic [31:0] sh_imem [IMEM_DEPTH];
  logic [15:0] sh_regs [REG_DEPTH];
  int ref_pc, ref_exec;
  bit ref_done;

  function automatic void ref_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                                  output logic [31:0] edata, output logic [1:0] estat,
                                  output int elat, output int een);
    int c;
    bit fin;
    edata = '0; estat = RSP_OK; elat = 1; een = 0;
    case (op)
      OP_WR_IMEM: sh_imem[addr] = data;
      OP_WR_REG: begin
        if (addr == 0) estat = RSP_ERR;
        else begin sh_regs[addr] = data[15:0]; elat = 2; end
      end
      OP_RD_REG: begin edata = {16'b0, sh_regs[addr]}; elat = 2; end
      OP_CLEAR: begin ref_pc = 0; ref_exec = 0; ref_done = 0; elat = 2; end
      OP_RUN: begin
        if (ref_done || data == 0) estat = RSP_ERR;
        else begin
          c = 0; fin = 0;
          while (!fin) begin
            c++;
            edata = 32'(ref_exec);
            if (ref_done) begin estat = RSP_OK; fin = 1; end
            else begin
              if (sh_imem[ref_pc] == HALT) ref_done = 1;
              else begin ref_exec++; ref_pc = (ref_pc + 1) % int'(IMEM_DEPTH); end
              if (32'(c) == data) begin estat = RSP_TIMEOUT; fin = 1; end
            end
          end
          een = c; elat = c + 1;
        end
      end
      OP_STATUS: begin edata = 32'(ref_exec); estat = ref_done ? RSP_OK : RSP_TIMEOUT; end
      default: estat = RSP_ERR;
    endcase
  endfunction

  // Stimulus driver: issue one command, collect its response, report latency
  // (posedges from accept to rsp_valid) and enabled-cycle count.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic [1:0] rstat, output int lat, output int en);
    int n, en0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; failures++; $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; en0 = en_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      checks++; failures++; $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
    end
    rdata = rsp_data; rstat = rsp_status; en = en_cnt - en0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd, ed;
  logic [1:0] rs, es;
  int lat, el, en, een;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dp_reset !== 1'b1) begin failures++; $display("FAIL reset_dp_reset: got %b required 1", dp_reset); end
    reset = 1'b0;
    for (int i = 0; i < int'(IMEM_DEPTH); i++) sh_imem[i] = '0;
    for (int i = 0; i < int'(REG_DEPTH); i++) sh_regs[i] = '0;
    ref_pc = 0; ref_exec = 0; ref_done = 0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_status, dp_enable, dp_reg_we, dp_reg_addr, dp_reset} !==
        {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b rd=%h rs=%0d en=%b we=%b ra=%0d dr=%b, required 1 0 0 0 0 0 0 0",
               cmd_ready, rsp_valid, rsp_data, rsp_status, dp_enable, dp_reg_we, dp_reg_addr, dp_reset);
    end
    checks++;
    if (dp_instructions !== '0) begin failures++; $display("FAIL reset_imem: got nonzero, required all 0"); end
  endtask

  task automatic test_wr_imem();
    logic [IMEM_DEPTH*INSTR_WIDTH-1:0] flat;
    logic [31:0] w;
    logic [4:0] a;
    logic [31:0] slice;
    ref_cmd(OP_WR_IMEM, 5'd3, 32'h0102_0304, ed, es, el, een);
    do_cmd(OP_WR_IMEM, 5'd3, 32'h0102_0304, rd, rs, lat, en);
    slice = dp_instructions[127:96];
    checks++;
    if ({slice, rs, lat} !== {32'h0102_0304, 2'd0, 32'd1}) begin
      failures++; $display("FAIL wr_imem3: word=%h st=%0d lat=%0d, required 01020304 0 1", slice, rs, lat);
    end
    for (int k = 0; k < 5; k++) begin
      a = 5'($urandom_range(0, 31));
      w = $urandom;
      if (w == HALT) w = 32'h0;
      ref_cmd(OP_WR_IMEM, a, w, ed, es, el, een);
      do_cmd(OP_WR_IMEM, a, w, rd, rs, lat, en);
    end
    for (int i = 0; i < int'(IMEM_DEPTH); i++) flat[i*INSTR_WIDTH +: INSTR_WIDTH] = sh_imem[i];
    checks++;
    if (dp_instructions !== flat) begin failures++; $display("FAIL wr_imem_image: got %h required %h", dp_instructions[159:0], flat[159:0]); end
  endtask

  task automatic test_reg_access();
    logic [2:0] op;
    logic [4:0] a;
    logic [31:0] d;
    ref_cmd(OP_WR_REG, 5'd5, 32'h1234, ed, es, el, een);
    do_cmd(OP_WR_REG, 5'd5, 32'h1234, rd, rs, lat, en);
    checks++;
    if ({rs, lat} !== {2'd0, 32'd2}) begin failures++; $display("FAIL wr_reg5: st=%0d lat=%0d, required 0 2", rs, lat); end
    ref_cmd(OP_RD_REG, 5'd5, 32'h0, ed, es, el, een);
    do_cmd(OP_RD_REG, 5'd5, 32'h0, rd, rs, lat, en);
    checks++;
    if ({rd, rs, lat} !== {32'h0000_1234, 2'd0, 32'd2}) begin
      failures++; $display("FAIL rd_reg5: data=%h st=%0d lat=%0d, required 00001234 0 2", rd, rs, lat);
    end
    ref_cmd(OP_WR_REG, 5'd0, 32'hBEEF, ed, es, el, een);
    do_cmd(OP_WR_REG, 5'd0, 32'hBEEF, rd, rs, lat, en);
    checks++;
    if (rs !== 2'd2) begin failures++; $display("FAIL wr_reg0_err: st=%0d required 2", rs); end
    for (int k = 0; k < 10; k++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_WR_REG : OP_RD_REG;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      ref_cmd(op, a, d, ed, es, el, een);
      do_cmd(op, a, d, rd, rs, lat, en);
      checks++;
      if ({rd, rs, lat} !== {ed, es, el}) begin
        failures++; $display("FAIL reg_rand op=%0d a=%0d: data=%h st=%0d lat=%0d, required %h %0d %0d", op, a, rd, rs, lat, ed, es, el);
      end
    end
  endtask

  task automatic test_run_halt();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = $urandom & 32'h7FFF_FFFF;
      ref_cmd(OP_WR_IMEM, 5'(i), w, ed, es, el, een);
      do_cmd(OP_WR_IMEM, 5'(i), w, rd, rs, lat, en);
    end
    ref_cmd(OP_WR_IMEM, 5'd4, HALT, ed, es, el, een);
    do_cmd(OP_WR_IMEM, 5'd4, HALT, rd, rs, lat, en);
    ref_cmd(OP_CLEAR, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_CLEAR, 5'd0, 32'h0, rd, rs, lat, en);
    ref_cmd(OP_RUN, 5'd0, 32'd100, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd100, rd, rs, lat, en);
    checks++;
    if ({rd, rs} !== {32'd4, 2'd0}) begin failures++; $display("FAIL run_halt: data=%0d st=%0d, required 4 0", rd, rs); end
    checks++;
    if ({lat, en} !== {el, een}) begin failures++; $display("FAIL run_halt_timing: lat=%0d en=%0d, required %0d %0d", lat, en, el, een); end
    checks++;
    if (dp_enable !== 1'b0) begin failures++; $display("FAIL run_halt_enable_after: got %b required 0", dp_enable); end
  endtask

  task automatic test_run_timeout();
    logic [31:0] b;
    ref_cmd(OP_WR_IMEM, 5'd4, 32'h0000_0011, ed, es, el, een);
    do_cmd(OP_WR_IMEM, 5'd4, 32'h0000_0011, rd, rs, lat, en);
    ref_cmd(OP_CLEAR, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_CLEAR, 5'd0, 32'h0, rd, rs, lat, en);
    ref_cmd(OP_RUN, 5'd0, 32'd10, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd10, rd, rs, lat, en);
    checks++;
    if ({rs, en} !== {2'd1, 32'd10}) begin failures++; $display("FAIL run_timeout10: st=%0d en=%0d, required 1 10", rs, en); end
    checks++;
    if ({rd, lat} !== {ed, el}) begin failures++; $display("FAIL run_timeout10_data: data=%0d lat=%0d, required %0d %0d", rd, lat, ed, el); end
    b = 32'($urandom_range(1, 20));
    ref_cmd(OP_RUN, 5'd0, b, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, b, rd, rs, lat, en);
    checks++;
    if ({rd, rs, lat, en} !== {ed, 2'd1, el, b}) begin
      failures++; $display("FAIL run_again b=%0d: data=%0d st=%0d lat=%0d en=%0d, required %0d 1 %0d %0d", b, rd, rs, lat, en, ed, el, b);
    end
  endtask

  task automatic test_run_errors();
    int c0;
    ref_cmd(OP_WR_IMEM, 5'd2, HALT, ed, es, el, een);
    do_cmd(OP_WR_IMEM, 5'd2, HALT, rd, rs, lat, en);
    c0 = clr_cnt;
    ref_cmd(OP_CLEAR, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_CLEAR, 5'd0, 32'h0, rd, rs, lat, en);
    checks++;
    if ({clr_cnt - c0, 30'd0, rs} !== {32'd1, 32'd0}) begin failures++; $display("FAIL clear_pulse: cycles=%0d st=%0d, required 1 0", clr_cnt - c0, rs); end
    ref_cmd(OP_RUN, 5'd0, 32'd3, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd3, rd, rs, lat, en);
    checks++;
    if ({rd, rs, en} !== {32'd2, 2'd1, 32'd3}) begin failures++; $display("FAIL run_budget_edge: data=%0d st=%0d en=%0d, required 2 1 3", rd, rs, en); end
    ref_cmd(OP_STATUS, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_STATUS, 5'd0, 32'h0, rd, rs, lat, en);
    checks++;
    if ({rd, rs, lat} !== {32'd2, 2'd0, 32'd1}) begin failures++; $display("FAIL status_done: data=%0d st=%0d lat=%0d, required 2 0 1", rd, rs, lat); end
    ref_cmd(OP_RUN, 5'd0, 32'd50, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd50, rd, rs, lat, en);
    checks++;
    if ({rs, en} !== {2'd2, 32'd0}) begin failures++; $display("FAIL run_when_done: st=%0d en=%0d, required 2 0", rs, en); end
    ref_cmd(OP_CLEAR, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_CLEAR, 5'd0, 32'h0, rd, rs, lat, en);
    ref_cmd(OP_RUN, 5'd0, 32'd0, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd0, rd, rs, lat, en);
    checks++;
    if ({rs, en} !== {2'd2, 32'd0}) begin failures++; $display("FAIL run_budget0: st=%0d en=%0d, required 2 0", rs, en); end
    ref_cmd(OP_RUN, 5'd0, 32'd50, ed, es, el, een);
    do_cmd(OP_RUN, 5'd0, 32'd50, rd, rs, lat, en);
    checks++;
    if ({rd, rs, en} !== {32'd2, 2'd0, een}) begin failures++; $display("FAIL run_after_clear: data=%0d st=%0d en=%0d, required 2 0 %0d", rd, rs, en, een); end
    for (int k = 6; k < 8; k++) begin
      c0 = clr_cnt;
      do_cmd(3'(k), 5'd1, 32'd5, rd, rs, lat, en);
      checks++;
      if ({rs, lat, en, clr_cnt - c0} !== {2'd2, 32'd1, 32'd0, 32'd0}) begin
        failures++; $display("FAIL illegal_op%0d: st=%0d lat=%0d en=%0d clr=%0d, required 2 1 0 0", k, rs, lat, en, clr_cnt - c0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cd;
    logic [1:0] cs;
    int n;
    ref_cmd(OP_STATUS, 5'd0, 32'h0, ed, es, el, een);
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = OP_STATUS; cmd_addr = '0; cmd_data = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    cd = rsp_data; cs = rsp_status;
    checks++;
    if ({rsp_valid, cd, cs} !== {1'b1, ed, es}) begin failures++; $display("FAIL bp_resp: rv=%b data=%h st=%0d, required 1 %h %0d", rsp_valid, cd, cs, ed, es); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_status} !== {1'b1, 1'b0, cd, cs}) begin
        failures++; $display("FAIL bp_hold%0d: rv=%b ready=%b data=%h st=%0d, required 1 0 %h %0d", k, rsp_valid, cmd_ready, rsp_data, rsp_status, cd, cs);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL bp_release: rv=%b ready=%b, required 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_reset_mid_run();
    ref_cmd(OP_WR_IMEM, 5'd2, 32'h22, ed, es, el, een);
    do_cmd(OP_WR_IMEM, 5'd2, 32'h22, rd, rs, lat, en);
    ref_cmd(OP_CLEAR, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_CLEAR, 5'd0, 32'h0, rd, rs, lat, en);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_addr = '0; cmd_data = 32'd1000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (dp_enable !== 1'b1) begin failures++; $display("FAIL midrun_enable: got %b required 1", dp_enable); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(IMEM_DEPTH); i++) sh_imem[i] = '0;
    ref_pc = 0; ref_exec = 0; ref_done = 0;
    checks++;
    if ({dp_enable, rsp_valid} !== 2'b00) begin failures++; $display("FAIL midrun_abort: en=%b rv=%b, required 0 0", dp_enable, rsp_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, dp_enable} !== 3'b010) begin
        failures++; $display("FAIL midrun_quiet%0d: rv=%b ready=%b en=%b, required 0 1 0", k, rsp_valid, cmd_ready, dp_enable);
      end
    end
    ref_cmd(OP_STATUS, 5'd0, 32'h0, ed, es, el, een);
    do_cmd(OP_STATUS, 5'd0, 32'h0, rd, rs, lat, en);
    checks++;
    if ({rd, rs, dp_instructions == '0} !== {32'd0, 2'd1, 1'b1}) begin
      failures++; $display("FAIL midrun_status: data=%0d st=%0d imem_zero=%b, required 0 1 1", rd, rs, dp_instructions == '0);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [4:0] a;
    logic [31:0] d;
    int r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      case (r)
        0: begin op = OP_WR_IMEM; if ($urandom_range(0, 3) == 0) d = HALT; end
        1, 2: op = OP_WR_REG;
        3, 4: op = OP_RD_REG;
        5: op = OP_CLEAR;
        6, 7: begin op = OP_RUN; d = 32'($urandom_range(0, 40)); end
        8: op = OP_STATUS;
        default: op = 3'($urandom_range(6, 7));
      endcase
      ref_cmd(op, a, d, ed, es, el, een);
      do_cmd(op, a, d, rd, rs, lat, en);
      checks++;
      if ({rd, rs, lat, en} !== {ed, es, el, een}) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%0d d=%h: data=%h st=%0d lat=%0d en=%0d, required %h %0d %0d %0d",
                 k, op, a, d, rd, rs, lat, en, ed, es, el, een);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wr_imem();
    test_reg_access();
    test_run_halt();
    test_run_timeout();
    test_run_errors();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
